// File: rtl/sim_to_seq_shift_ctrl.sv
// sim_to_seq_shift_ctrl
//
// Sequencing controller for the parallel-in/serial-out shift register in the
// BCH decoder datapath. It captures a parallel frame on request, then shifts
// one word out every CLK_DISTANCE clocks. Per-word strobes go to the serial
// consumer. With PASSING_FIR set, word 0 goes straight through during the
// load cycle, so the register only shifts out words 1..SHIFT_LEN-1.
//
// Handshake semantics (the single rule for this block):
//   - Upstream: in_load_req is a level "frame ready". The frame counts as
//     transferred only in the cycle where out_load_ack is high. Parallel
//     data must stay stable until that cycle.
//   - Downstream: out_word_vld marks a word transfer. in_hold is the inverse
//     of ready: while it is high, no word is presented and nothing advances.
//   - in_ctr_en low freezes everything and forces every strobe low.
//
// Ports:
//   clk            sole clock, rising edge
//   in_ctr_Srst    synchronous reset, active-high (overrides in_ctr_en)
//   in_ctr_en      global enable
//   in_load_req    parallel frame ready
//   in_hold        downstream stall
//   out_ctr_init   register parallel load
//   out_ctr_sft_en register shift enable
//   out_ctr_en     copy of in_ctr_en for the register
//   out_load_ack   one-cycle pulse when the frame is captured
//   out_word_vld   serial word sampled this cycle
//   out_word_idx   index of the sampled word (0 when no word is valid)
//   out_last       sampled word is the last of the frame
//   out_busy       controller is not idle
//   dbg_state      current FSM state, for observation only
module sim_to_seq_shift_ctrl #(
    parameter int SHIFT_LEN    = 4,
    parameter int CLK_DISTANCE = 1,
    parameter int PASSING_FIR  = 0,
    localparam int IDX_W = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1
) (
    input  logic             clk,
    input  logic             in_ctr_Srst,
    input  logic             in_ctr_en,
    input  logic             in_load_req,
    input  logic             in_hold,
    output logic             out_ctr_init,
    output logic             out_ctr_sft_en,
    output logic             out_ctr_en,
    output logic             out_load_ack,
    output logic             out_word_vld,
    output logic [IDX_W-1:0] out_word_idx,
    output logic             out_last,
    output logic             out_busy,
    output logic [1:0]       dbg_state
);

    // A dwell of 0 clocks has no meaning, so it runs as a dwell of 1.
    localparam int CD_EFF = (CLK_DISTANCE < 1) ? 1 : CLK_DISTANCE;
    localparam int DIST_W = (CD_EFF > 1) ? $clog2(CD_EFF) : 1;

    localparam logic [DIST_W-1:0] DIST_LAST = DIST_W'(CD_EFF - 1);
    localparam logic [DIST_W-1:0] DIST_ONE  = DIST_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SHIFT_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic              PF        = (PASSING_FIR != 0);
    localparam logic              SINGLE    = (SHIFT_LEN == 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]        state;
    logic [DIST_W-1:0] dist_cnt;
    logic [IDX_W-1:0]  idx;

    logic stall;
    logic load_go;
    logic fire;

    // The outputs depend only on registered state, in_hold and in_ctr_en.
    // in_load_req affects only the next-state logic.
    always_comb begin
        stall   = !in_ctr_en || in_hold;
        load_go = (state == ST_LOAD) && !stall;
        fire    = (state == ST_RUN) && (dist_cnt == DIST_LAST) && !stall;

        out_ctr_en     = in_ctr_en;
        out_ctr_init   = (state == ST_LOAD) && in_ctr_en;
        out_load_ack   = load_go;
        out_ctr_sft_en = fire;
        // In the passing-first variant, word 0 is presented directly
        // from the parallel input during the accepted load cycle.
        out_word_vld   = fire || (load_go && PF);
        out_word_idx   = fire ? idx : '0;
        out_last       = (fire && (idx == IDX_LAST)) || (load_go && PF && SINGLE);
        out_busy       = (state != ST_IDLE);
        dbg_state      = state;
    end

    always_ff @(posedge clk) begin
        if (in_ctr_Srst) begin
            state    <= ST_IDLE;
            dist_cnt <= '0;
            idx      <= '0;
        end else if (in_ctr_en) begin
            case (state)
                ST_IDLE: begin
                    if (in_load_req) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // While held, init stays high and the register keeps
                    // recapturing the same stable parallel word.
                    if (!in_hold) begin
                        dist_cnt <= '0;
                        if (PF) begin
                            if (SINGLE) begin
                                state <= ST_IDLE;
                                idx   <= '0;
                            end else begin
                                state <= ST_RUN;
                                idx   <= IDX_ONE;
                            end
                        end else begin
                            state <= ST_RUN;
                            idx   <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (!in_hold) begin
                        if (dist_cnt == DIST_LAST) begin
                            dist_cnt <= '0;
                            if (idx == IDX_LAST) begin
                                idx <= '0;
                                // The request is sampled only at the last-word fire.
                                // This allows back-to-back frames with a single
                                // load cycle between them.
                                state <= in_load_req ? ST_LOAD : ST_IDLE;
                            end else begin
                                idx <= idx + IDX_ONE;
                            end
                        end else begin
                            dist_cnt <= dist_cnt + DIST_ONE;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    dist_cnt <= '0;
                    idx      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_to_seq_shift_ctrl.sv
// Directed bench for sim_to_seq_shift_ctrl. Four instances share one set of
// inputs:
//   A: SHIFT_LEN=4, CLK_DISTANCE=2, PF=0
//   B: SHIFT_LEN=4, CLK_DISTANCE=2, PF=1
//   C: SHIFT_LEN=1, CLK_DISTANCE=0, PF=1
//   D: SHIFT_LEN=1, CLK_DISTANCE=0, PF=0
// Cycle numbering: cycle 0 is the first cycle after reset is released.
// Inputs change 1 time unit after the rising edge, and outputs are sampled
// on the falling edge.
module tb_sim_to_seq_shift_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, req, hold;

    logic       a_init, a_sft, a_en, a_ack, a_vld, a_last, a_busy;
    logic [1:0] a_idx, a_st;
    logic       b_init, b_sft, b_en, b_ack, b_vld, b_last, b_busy;
    logic [1:0] b_idx, b_st;
    logic       c_init, c_sft, c_en, c_ack, c_vld, c_last, c_busy;
    logic [0:0] c_idx;
    logic [1:0] c_st;
    logic       d_init, d_sft, d_en, d_ack, d_vld, d_last, d_busy;
    logic [0:0] d_idx;
    logic [1:0] d_st;

    int checks = 0;
    int errors = 0;

    sim_to_seq_shift_ctrl #(.SHIFT_LEN(4), .CLK_DISTANCE(2), .PASSING_FIR(0)) dut_a (
        .clk(clk), .in_ctr_Srst(rst), .in_ctr_en(en), .in_load_req(req), .in_hold(hold),
        .out_ctr_init(a_init), .out_ctr_sft_en(a_sft), .out_ctr_en(a_en),
        .out_load_ack(a_ack), .out_word_vld(a_vld), .out_word_idx(a_idx),
        .out_last(a_last), .out_busy(a_busy), .dbg_state(a_st));

    sim_to_seq_shift_ctrl #(.SHIFT_LEN(4), .CLK_DISTANCE(2), .PASSING_FIR(1)) dut_b (
        .clk(clk), .in_ctr_Srst(rst), .in_ctr_en(en), .in_load_req(req), .in_hold(hold),
        .out_ctr_init(b_init), .out_ctr_sft_en(b_sft), .out_ctr_en(b_en),
        .out_load_ack(b_ack), .out_word_vld(b_vld), .out_word_idx(b_idx),
        .out_last(b_last), .out_busy(b_busy), .dbg_state(b_st));

    sim_to_seq_shift_ctrl #(.SHIFT_LEN(1), .CLK_DISTANCE(0), .PASSING_FIR(1)) dut_c (
        .clk(clk), .in_ctr_Srst(rst), .in_ctr_en(en), .in_load_req(req), .in_hold(hold),
        .out_ctr_init(c_init), .out_ctr_sft_en(c_sft), .out_ctr_en(c_en),
        .out_load_ack(c_ack), .out_word_vld(c_vld), .out_word_idx(c_idx),
        .out_last(c_last), .out_busy(c_busy), .dbg_state(c_st));

    sim_to_seq_shift_ctrl #(.SHIFT_LEN(1), .CLK_DISTANCE(0), .PASSING_FIR(0)) dut_d (
        .clk(clk), .in_ctr_Srst(rst), .in_ctr_en(en), .in_load_req(req), .in_hold(hold),
        .out_ctr_init(d_init), .out_ctr_sft_en(d_sft), .out_ctr_en(d_en),
        .out_load_ack(d_ack), .out_word_vld(d_vld), .out_word_idx(d_idx),
        .out_last(d_last), .out_busy(d_busy), .dbg_state(d_st));

    // Packed view of one instance: {ctr_en, init, sft_en, ack, vld, idx[1:0], last, busy}.
    function automatic logic [8:0] pk(input logic ce, input logic init, input logic sft,
                                      input logic ack, input logic vld, input logic [1:0] idx,
                                      input logic last, input logic busy);
        return {ce, init, sft, ack, vld, idx, last, busy};
    endfunction

    logic [8:0] obs_a, obs_b, obs_c, obs_d;
    assign obs_a = pk(a_en, a_init, a_sft, a_ack, a_vld, a_idx, a_last, a_busy);
    assign obs_b = pk(b_en, b_init, b_sft, b_ack, b_vld, b_idx, b_last, b_busy);
    assign obs_c = pk(c_en, c_init, c_sft, c_ack, c_vld, {1'b0, c_idx}, c_last, c_busy);
    assign obs_d = pk(d_en, d_init, d_sft, d_ack, d_vld, {1'b0, d_idx}, d_last, d_busy);

    // Hand-derived baseline schedule for instance A (request pulse at cycle 0):
    // init/ack at cycle 1, words at cycles 3,5,7,9, last at 9, busy 1..9.
    function automatic logic [8:0] base_a(input int c);
        logic       v;
        logic [1:0] ix;
        v  = (c >= 3) && (c <= 9) && (c % 2 == 1);
        ix = v ? 2'((c - 3) / 2) : 2'd0;
        return pk(1'b1, c == 1, v, c == 1, v, ix, c == 9, (c >= 1) && (c <= 9));
    endfunction

    // Applies reset with idle inputs and leaves the bench at the start of cycle 0.
    task automatic do_reset();
        rst  = 1'b1;
        en   = 1'b1;
        req  = 1'b0;
        hold = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (obs_a !== pk(1, 0, 0, 0, 0, 2'd0, 0, 0)) begin
            errors++;
            $display("FAIL reset_a got=%b exp=%b", obs_a, pk(1, 0, 0, 0, 0, 2'd0, 0, 0));
        end
        checks++;
        if (obs_b !== pk(1, 0, 0, 0, 0, 2'd0, 0, 0)) begin
            errors++;
            $display("FAIL reset_b got=%b exp=%b", obs_b, pk(1, 0, 0, 0, 0, 2'd0, 0, 0));
        end
        checks++;
        if (obs_c !== pk(1, 0, 0, 0, 0, 2'd0, 0, 0)) begin
            errors++;
            $display("FAIL reset_c got=%b exp=%b", obs_c, pk(1, 0, 0, 0, 0, 2'd0, 0, 0));
        end
        checks++;
        if (obs_d !== pk(1, 0, 0, 0, 0, 2'd0, 0, 0)) begin
            errors++;
            $display("FAIL reset_d got=%b exp=%b", obs_d, pk(1, 0, 0, 0, 0, 2'd0, 0, 0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_baseline();
        logic [8:0] e;
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            req = (c == 0);
            @(negedge clk);
            e = base_a(c);
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL baseline c=%0d got=%b exp=%b", c, obs_a, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_passing_first();
        logic [8:0] e;
        logic       v, s;
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            req = (c == 0);
            @(negedge clk);
            s = (c >= 3) && (c <= 7) && (c % 2 == 1);
            v = (c == 1) || s;
            e = pk(1, c == 1, s, c == 1, v, v ? 2'((c - 1) / 2) : 2'd0, c == 7,
                   (c >= 1) && (c <= 7));
            checks++;
            if (obs_b !== e) begin
                errors++;
                $display("FAIL passing_first c=%0d got=%b exp=%b", c, obs_b, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] e;
        logic       v;
        logic [1:0] ix;
        // Hold during RUN, cycles 5-7.
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            req  = (c == 0);
            hold = (c >= 5) && (c <= 7);
            @(negedge clk);
            v  = (c == 3) || (c == 8) || (c == 10) || (c == 12);
            ix = (c == 8) ? 2'd1 : (c == 10) ? 2'd2 : (c == 12) ? 2'd3 : 2'd0;
            e  = pk(1, c == 1, v, c == 1, v, ix, c == 12, (c >= 1) && (c <= 12));
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL hold_run c=%0d got=%b exp=%b", c, obs_a, e);
            end
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
        // Hold during the LOAD cycle: init persists, ack moves to cycle 2.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            req  = (c == 0);
            hold = (c == 1);
            @(negedge clk);
            v  = (c >= 4) && (c <= 10) && (c % 2 == 0);
            ix = v ? 2'((c - 4) / 2) : 2'd0;
            e  = pk(1, (c == 1) || (c == 2), v, c == 2, v, ix, c == 10, (c >= 1) && (c <= 10));
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL hold_load c=%0d got=%b exp=%b", c, obs_a, e);
            end
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            req = 1'b1;
            @(negedge clk);
            // The second frame repeats the baseline schedule 9 cycles later.
            e = base_a((c >= 10) ? c - 9 : c);
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs_a, e);
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] e;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            req = (c == 0) || (c == 10);
            rst = (c == 6);
            @(negedge clk);
            e = (c <= 6) ? base_a(c) : (c >= 10) ? base_a(c - 10) : base_a(0);
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL reset_mid c=%0d got=%b exp=%b", c, obs_a, e);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_enable();
        logic [8:0] e;
        logic       v;
        logic [1:0] ix;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            req = (c == 0);
            en  = !((c == 4) || (c == 5));
            @(negedge clk);
            v  = (c == 3) || (c == 7) || (c == 9) || (c == 11);
            ix = (c == 7) ? 2'd1 : (c == 9) ? 2'd2 : (c == 11) ? 2'd3 : 2'd0;
            e  = pk(en, c == 1, v, c == 1, v, ix, c == 11, (c >= 1) && (c <= 11));
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL enable c=%0d got=%b exp=%b", c, obs_a, e);
            end
            @(posedge clk);
            #1;
        end
        en = 1'b1;
    endtask

    task automatic test_degenerate();
        logic [8:0] ec, ed;
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            req = (c == 0);
            @(negedge clk);
            ec = (c == 1) ? pk(1, 1, 0, 1, 1, 2'd0, 1, 1) : pk(1, 0, 0, 0, 0, 2'd0, 0, 0);
            ed = (c == 1) ? pk(1, 1, 0, 1, 0, 2'd0, 0, 1) :
                 (c == 2) ? pk(1, 0, 1, 0, 1, 2'd0, 1, 1) : pk(1, 0, 0, 0, 0, 2'd0, 0, 0);
            checks++;
            if (obs_c !== ec) begin
                errors++;
                $display("FAIL degenerate_pf c=%0d got=%b exp=%b", c, obs_c, ec);
            end
            checks++;
            if (obs_d !== ed) begin
                errors++;
                $display("FAIL degenerate_nopf c=%0d got=%b exp=%b", c, obs_d, ed);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        req  = 1'b0;
        hold = 1'b0;
        test_reset();
        test_baseline();
        test_passing_first();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_enable();
        test_degenerate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sim_to_seq_shift_ctrl.md
# sim_to_seq_shift_ctrl

Sequencing controller for the parallel-in/serial-out simultaneous-to-sequential shift register used in the BCH decoder datapath, including its passing-first variant. Accepts a frame-load request, drives the register's `init` and `sft_en` controls, and spaces words `CLK_DISTANCE` clocks apart. Emits per-word valid, index and last strobes for the downstream serial consumer, and honours downstream backpressure.

## Interface
- `SHIFT_LEN`, 4: words per frame; must be ≥1.
- `CLK_DISTANCE`, 1: clocks per word dwell; 0 is treated as 1.
- `PASSING_FIR`, 0: nonzero means word 0 bypasses the register during the init cycle.
- `IDX_W`, localparam: max(1, ceil(log2(SHIFT_LEN))).
- `clk`  in  1  sole clock, rising edge.
- `in_ctr_Srst`  in  1  synchronous reset, active-high.
- `in_ctr_en`  in  1  global enable; low freezes all state.
- `in_load_req`  in  1  parallel frame ready; parallel data must stay stable until `out_load_ack`.
- `in_hold`  in  1  downstream stall.
- `out_ctr_init`  out  1  register parallel load.
- `out_ctr_sft_en`  out  1  register shift enable.
- `out_ctr_en`  out  1  equals `in_ctr_en`.
- `out_load_ack`  out  1  one-cycle pulse when the frame is captured.
- `out_word_vld`  out  1  serial word sampled this cycle.
- `out_word_idx`  out  IDX_W  index of the sampled word.
- `out_last`  out  1  sampled word is index SHIFT_LEN-1.
- `out_busy`  out  1  state ≠ IDLE.

## Operation
- **States:** IDLE, LOAD, RUN. Counters: `dist_cnt` (0..CLK_DISTANCE-1) and `idx` (0..SHIFT_LEN-1).
- **Stall definition:** stall = `!in_ctr_en | in_hold`. When `in_ctr_en`=0, all strobes are forced to 0 and state/counters hold.
- **IDLE:** on `in_load_req`=1 and `in_ctr_en`=1, go to LOAD. Otherwise remain.
- **LOAD:**
  - `out_ctr_init`=1 while `in_ctr_en`=1.
  - `out_load_ack` = !stall.
  - If stall, remain in LOAD; `init` stays asserted and re-captures the same data.
  - If `PASSING_FIR`≠0 and !stall: `out_word_vld`=1, idx=0, `out_last`=(SHIFT_LEN==1).
  - Exit:
    - PF=1 and SHIFT_LEN=1: go to IDLE.
    - PF=1 otherwise: go to RUN with idx=1.
    - PF=0: go to RUN with idx=0.
  - `dist_cnt` is cleared on exit.
- **RUN:**
  - Each non-stalled cycle, `dist_cnt` increments.
  - When `dist_cnt`==CLK_DISTANCE-1 and !stall, fire:
    - `out_ctr_sft_en`=1, `out_word_vld`=1, `out_word_idx`=idx.
    - `dist_cnt`←0, idx←idx+1.
  - On a fire with idx==SHIFT_LEN-1:
    - `out_last`=1, idx←0.
    - Next state is LOAD if `in_load_req`=1 (back-to-back), else IDLE.
  - `in_hold` suppresses `sft_en`/`vld` and freezes both counters.
- **Strobe validity:** `out_word_idx` and `out_last` are 0 whenever `out_word_vld`=0.
- **Arithmetic:** counters wrap only through the explicit compares above; no modular overflow is permitted.
- **Request timing:** `in_load_req` is ignored in RUN except at the last-word fire.

## Timing
- **Reset:** `in_ctr_Srst`=1 at an edge → state IDLE, counters 0. All outputs are 0 the next cycle, except `out_ctr_en`, which follows its input.
- **Reset priority:** reset overrides `in_ctr_en`. A mid-frame reset aborts the frame with no `out_last`.
- **Output type:** strobes are Moore/Mealy mixes of registered state with `in_hold` and `in_ctr_en` only. No combinational path from `in_load_req` to any output.
- **Latency, PF=0:** request sampled in IDLE at cycle t.
  - `init`/`ack` at t+1.
  - Word k valid at t+1+(k+1)·CLK_DISTANCE.
- **Latency, PF=1:** word 0 at t+1; word k≥1 at t+1+k·CLK_DISTANCE.
- **Frame period:** back-to-back frames lose exactly one cycle (the LOAD cycle) per frame.

## Test plan
- **Baseline, PF=0:** SHIFT_LEN=4, CLK_DISTANCE=2; req pulse at cycle 0 → `init`/`ack` at 1; `vld`+`sft_en` at 3,5,7,9 with idx 0,1,2,3; `last` at 9; `busy` high 1..9, low at 10.
- **Passing-first:** same parameters with PF=1 → `init`, `ack`, `vld` idx0 all at 1 with no `sft_en`; idx1..3 at 3,5,7; `last` at 7.
- **Backpressure:** PF=0 baseline with `in_hold`=1 during cycles 5–7 → idx1 at 8, idx2 at 10, idx3+`last` at 12; no `sft_en` in 5–7. Hold asserted during LOAD at cycle 1 → `init` stays high and `ack` is delayed to the first unheld cycle.
- **Back-to-back:** PF=0 baseline with req held high → `last` at 9, `init`/`ack` at 10, next idx0 at 12; idle gap between frames is zero.
- **Reset and enable:** reset at cycle 6 of the baseline → from cycle 7 all strobes 0, `busy` 0, no `last`; a new req then starts cleanly. Separately, `in_ctr_en`=0 during cycles 4–5 → schedule shifts by 2 cycles (idx1 at 7).
- **Degenerate:** SHIFT_LEN=1, CLK_DISTANCE=0, PF=1 → cycle 1 has `init`, `ack`, `vld` idx0 and `last`; cycle 2 is IDLE. The same case with PF=0 gives `vld`+`last` at 2.
